// File: rtl/fir_pkg.sv
// Shared defaults and sample type for the FIR front-end blocks.
package fir_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_CHANNELS   = 2;
  localparam int DEF_PSAMPLES   = 8;

  typedef logic signed [DEF_DATA_WIDTH-1:0] sample_t;

  // Width of a lane index; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_lane_sreg.sv
// One channel's collect buffer: PSAMPLES lanes, written one lane per beat.
// merged_o is the buffer with the lane being written replaced by the
// incoming sample, so a closing beat can be captured in the same cycle.
module fir_lane_sreg
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PSAMPLES   = DEF_PSAMPLES,
  localparam int CNT_W     = cnt_width(PSAMPLES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr_i,
  input  logic                           we_i,
  input  logic [CNT_W-1:0]               wlane_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  output logic [PSAMPLES*DATA_WIDTH-1:0] merged_o
);

  logic [PSAMPLES*DATA_WIDTH-1:0] buf_q;
  logic [PSAMPLES*DATA_WIDTH-1:0] buf_d;

  // Next buffer state: clear wins over write so lanes above a flushed
  // partial word are zero for the following word.
  always_comb begin
    buf_d = buf_q;
    if (clr_i) begin
      buf_d = '0;
    end else if (we_i) begin
      for (int k = 0; k < PSAMPLES; k++) begin
        if (wlane_i == CNT_W'(k)) buf_d[k*DATA_WIDTH +: DATA_WIDTH] = wdata_i;
      end
    end
  end

  // Buffer register.
  always_ff @(posedge clk) begin
    if (rst) buf_q <= '0;
    else     buf_q <= buf_d;
  end

  // Bypass view of the current beat into its lane.
  always_comb begin
    merged_o = buf_q;
    for (int k = 0; k < PSAMPLES; k++) begin
      if (wlane_i == CNT_W'(k)) merged_o[k*DATA_WIDTH +: DATA_WIDTH] = wdata_i;
    end
  end

endmodule

// File: rtl/fir_lane_packer.sv
// Packs per-beat multichannel samples into PSAMPLES-lane words for the FIR.
// A word closes on its last lane or on s_tlast; a partial word is zero-filled.
module fir_lane_packer
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int PSAMPLES   = DEF_PSAMPLES
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    s_tvalid,
  output logic                                    s_tready,
  input  logic [CHANNELS*DATA_WIDTH-1:0]          s_tdata,
  input  logic                                    s_tlast,
  output logic                                    m_tvalid,
  input  logic                                    m_tready,
  output logic [CHANNELS*PSAMPLES*DATA_WIDTH-1:0] m_tdata,
  output logic                                    m_tlast,
  output logic [$clog2(PSAMPLES+1)-1:0]           m_nlanes
);

  localparam int CNT_W  = cnt_width(PSAMPLES);
  localparam int NL_W   = $clog2(PSAMPLES+1);
  localparam int WORD_W = CHANNELS*PSAMPLES*DATA_WIDTH;

  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic              tvalid_q, tvalid_d;
  logic [WORD_W-1:0] tdata_q,  tdata_d;
  logic              tlast_q,  tlast_d;
  logic [NL_W-1:0]   nlanes_q, nlanes_d;

  logic              closing;
  logic              accept;
  logic [WORD_W-1:0] merged;

  // A closing beat is only refused while an unconsumed word is still held;
  // this uses s_tlast but never s_tvalid.
  assign closing  = (cnt_q == CNT_W'(PSAMPLES-1)) || s_tlast;
  assign s_tready = !rst && !(tvalid_q && !m_tready && closing);
  assign accept   = s_tvalid && s_tready;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    fir_lane_sreg #(
      .DATA_WIDTH(DATA_WIDTH),
      .PSAMPLES  (PSAMPLES)
    ) u_sreg (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (accept && closing),
      .we_i    (accept && !closing),
      .wlane_i (cnt_q),
      .wdata_i (s_tdata[c*DATA_WIDTH +: DATA_WIDTH]),
      .merged_o(merged[c*PSAMPLES*DATA_WIDTH +: PSAMPLES*DATA_WIDTH])
    );
  end

  // Next state: lane counter advance, output word load on close, and
  // m_tvalid drop on a handshake that is not refilled in the same cycle.
  always_comb begin
    cnt_d    = cnt_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    nlanes_d = nlanes_q;
    if (accept) begin
      cnt_d = closing ? '0 : cnt_q + CNT_W'(1);
    end
    if (accept && closing) begin
      tvalid_d = 1'b1;
      tdata_d  = merged;
      tlast_d  = s_tlast;
      nlanes_d = NL_W'(cnt_q) + NL_W'(1);
    end else if (tvalid_q && m_tready) begin
      tvalid_d = 1'b0;
    end
  end

  // State registers; reset discards any partial or pending word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      nlanes_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      nlanes_q <= nlanes_d;
    end
  end

  assign m_tvalid = tvalid_q;
  assign m_tdata  = tdata_q;
  assign m_tlast  = tlast_q;
  assign m_nlanes = nlanes_q;

endmodule
